csr_intr_unit: RTL and testbench
================================

CSR_INTR_UNIT -- requirements
Module: csr_intr_unit

Interface
REQ-001 Parameter: MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  synchronous, active-low reset (0 = reset).
REQ-004 Port: timer_intrpt  in  1  timer interrupt pulse, one cycle wide.
REQ-005 Port: csr_we  in  1  CSR write enable from the execute stage.
REQ-006 Port: csr_addr  in  12  CSR address for read and write.
REQ-007 Port: csr_wdata  in  32  CSR write data.
REQ-008 Port: csr_rdata  out  32  combinational read of csr_addr; unmapped addresses read 0.
REQ-009 Port: commit_pc  in  32  PC of the oldest interruptible instruction.
REQ-010 Port: commit_valid  in  1  commit_pc is valid and the instruction can be interrupted.
REQ-011 Port: is_mret  in  1  MRET retiring this cycle.
REQ-012 Port: trap_req  out  1  interrupt redirect request to the pipeline.
REQ-013 Port: trap_ack  in  1  pipeline has flushed and accepted the redirect.
REQ-014 Port: redirect_pc  out  32  target PC: trap vector while trap_req is high, mepc while is_mret is high, else 0.

Function
REQ-015 CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7; other bits read 0), mie 0x304 (MTIE bit 7 only), mtvec 0x305, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mip 0x344 (MTIP bit 7, read-only).
REQ-016 A write to mip or an unmapped address is ignored.
REQ-017 MTIP sets on the cycle after timer_intrpt=1 and clears on the cycle after trap_ack=1.
REQ-018 If timer_intrpt and trap_ack are both 1 in the same cycle, MTIP stays 1.
REQ-019 FSM states: IDLE, REQ, HANDLER.
REQ-020 IDLE->REQ when MTIP & MTIE & MIE & commit_valid & !is_mret; latch commit_pc into mepc on that transition.
REQ-021 trap_req=1 exactly while in REQ and holds until trap_ack; trap_ack outside REQ is ignored.
REQ-022 REQ->HANDLER on trap_ack; on that edge: mcause=32'h8000_0007, MPIE<=MIE, MIE<=0, MTIP<=0 (subject to REQ-018).
REQ-023 HANDLER->IDLE on is_mret; on that edge: MIE<=MPIE, MPIE<=1.
REQ-024 is_mret in IDLE restores MIE/MPIE per REQ-023 and stays in IDLE.
REQ-025 is_mret in REQ is ignored; trap_req stays asserted.
REQ-026 A CSR write in the same cycle as a trap_ack or is_mret update of the same field loses; the hardware update wins.
REQ-027 A CSR write to mstatus that clears MIE while in REQ does not withdraw trap_req.
REQ-028 Latency: an enabled timer pulse with commit_valid=1 gives trap_req=1 two cycles after the pulse.

Reset
REQ-029 On rst=0 at a rising edge: FSM=IDLE, trap_req=0, mstatus=0, mie=0, mip=0, mepc=0, mcause=0, mtvec=MTVEC_RST.
REQ-030 Reset in REQ or HANDLER abandons the trap with no mepc/mcause update; redirect_pc reads 0 the next cycle.

Configuration
REQ-031 Macro: INTR_VECTORED_EN.
REQ-032 With INTR_VECTORED_EN defined: mtvec[1:0] is writable; if mtvec[1:0]==2'b01, the trap vector is {mtvec[31:2],2'b00}+28; otherwise the trap vector is {mtvec[31:2],2'b00}.
REQ-033 Without INTR_VECTORED_EN: mtvec[1:0] is hardwired 0 and reads 0; the trap vector is {mtvec[31:2],2'b00}.

Verification
REQ-034 Reset, then read all six CSRs -> mtvec=MTVEC_RST, others 0, trap_req=0.
REQ-035 Set MIE=1 and MTIE=1, mtvec=0x100; pulse timer with commit_pc=0x40 -> trap_req=1 with redirect_pc=0x100; after ack: mepc=0x40, mcause=0x8000_0007, MIE=0, MPIE=1, MTIP=0.
REQ-036 Timer pulse with MIE=0 -> MTIP=1, no trap_req; then write MIE=1 -> trap_req two cycles later.
REQ-037 Timer pulse in the same cycle as trap_ack -> MTIP=1 after the edge; a second trap is taken after MRET restores MIE=1.
REQ-038 In HANDLER, is_mret with mepc=0x40 -> redirect_pc=0x40, FSM=IDLE, MIE=1.
REQ-039 Vectored mtvec=0x101 -> redirect_pc=0x11C with INTR_VECTORED_EN defined, 0x100 without; rst=0 during REQ -> trap_req=0 next cycle.

Source files
------------

// File: rtl/csr_intr_unit_if.sv
// Pipeline <-> CSR/interrupt unit bus: CSR access, commit info and trap redirect handshake.
interface csr_intr_unit_if;
  logic        timer_intrpt;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] commit_pc;
  logic        commit_valid;
  logic        is_mret;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] redirect_pc;

  modport master (
    output timer_intrpt, csr_we, csr_addr, csr_wdata, commit_pc, commit_valid, is_mret, trap_ack,
    input  csr_rdata, trap_req, redirect_pc
  );

  modport slave (
    input  timer_intrpt, csr_we, csr_addr, csr_wdata, commit_pc, commit_valid, is_mret, trap_ack,
    output csr_rdata, trap_req, redirect_pc
  );
endinterface

// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file with a timer-interrupt trap FSM (IDLE/REQ/HANDLER).
// Optional INTR_VECTORED_EN: writable mtvec mode bits and vectored timer entry (+28).
module csr_intr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  csr_intr_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_HANDLER = 2'd2;

  localparam logic [XLEN-1:0] MCAUSE_MTI = 32'h8000_0007;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
`ifdef INTR_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic [1:0]      r_state, w_state_nxt;
  logic            r_mie, w_mie_nxt;
  logic            r_mpie, w_mpie_nxt;
  logic            r_mtie, w_mtie_nxt;
  logic            r_mtip, w_mtip_nxt;
  logic [XLEN-1:0] r_mtvec, w_mtvec_nxt;
  logic [XLEN-1:0] r_mepc, w_mepc_nxt;
  logic [XLEN-1:0] r_mcause, w_mcause_nxt;

  logic            w_take, w_ack, w_mret;
  logic [XLEN-1:0] w_trap_vec;
  logic [XLEN-1:0] w_rdata;

  assign w_take = (r_state == S_IDLE) && r_mtip && r_mtie && r_mie &&
                  bus.commit_valid && !bus.is_mret;
  assign w_ack  = (r_state == S_REQ) && bus.trap_ack;
  assign w_mret = bus.is_mret && (r_state != S_REQ);

`ifdef INTR_VECTORED_EN
  assign w_trap_vec = (r_mtvec & ALIGN_MASK) +
                      ((r_mtvec[1:0] == 2'b01) ? XLEN'(28) : XLEN'(0));
`else
  assign w_trap_vec = r_mtvec & ALIGN_MASK;
`endif

  // Next-state and CSR update; hardware trap/mret updates take priority over CSR writes.
  always_comb begin
    w_state_nxt  = r_state;
    w_mie_nxt    = r_mie;
    w_mpie_nxt   = r_mpie;
    w_mtie_nxt   = r_mtie;
    w_mtip_nxt   = r_mtip;
    w_mtvec_nxt  = r_mtvec;
    w_mepc_nxt   = r_mepc;
    w_mcause_nxt = r_mcause;

    case (r_state)
      S_IDLE:    if (w_take)      w_state_nxt = S_REQ;
      S_REQ:     if (w_ack)       w_state_nxt = S_HANDLER;
      S_HANDLER: if (bus.is_mret) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase

    if (w_ack) begin
      w_mpie_nxt = r_mie;
      w_mie_nxt  = 1'b0;
    end else if (w_mret) begin
      w_mie_nxt  = r_mpie;
      w_mpie_nxt = 1'b1;
    end else if (bus.csr_we && bus.csr_addr == ADDR_MSTATUS) begin
      w_mie_nxt  = bus.csr_wdata[3];
      w_mpie_nxt = bus.csr_wdata[7];
    end

    // A new pulse outranks the ack-driven clear so no timer event is lost.
    if (bus.timer_intrpt) w_mtip_nxt = 1'b1;
    else if (w_ack)       w_mtip_nxt = 1'b0;

    if (w_take)
      w_mepc_nxt = bus.commit_pc & ALIGN_MASK;
    else if (bus.csr_we && bus.csr_addr == ADDR_MEPC)
      w_mepc_nxt = bus.csr_wdata & ALIGN_MASK;

    if (w_ack)
      w_mcause_nxt = MCAUSE_MTI;
    else if (bus.csr_we && bus.csr_addr == ADDR_MCAUSE)
      w_mcause_nxt = bus.csr_wdata;

    if (bus.csr_we && bus.csr_addr == ADDR_MIE)
      w_mtie_nxt = bus.csr_wdata[7];
    if (bus.csr_we && bus.csr_addr == ADDR_MTVEC)
      w_mtvec_nxt = bus.csr_wdata & MTVEC_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtie   <= 1'b0;
      r_mtip   <= 1'b0;
      r_mtvec  <= MTVEC_RST & MTVEC_MASK;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mie    <= w_mie_nxt;
      r_mpie   <= w_mpie_nxt;
      r_mtie   <= w_mtie_nxt;
      r_mtip   <= w_mtip_nxt;
      r_mtvec  <= w_mtvec_nxt;
      r_mepc   <= w_mepc_nxt;
      r_mcause <= w_mcause_nxt;
    end
  end

  // Combinational CSR read port.
  always_comb begin
    w_rdata = '0;
    case (bus.csr_addr)
      ADDR_MSTATUS: w_rdata = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      ADDR_MIE:     w_rdata = {24'd0, r_mtie, 7'd0};
      ADDR_MTVEC:   w_rdata = r_mtvec;
      ADDR_MEPC:    w_rdata = r_mepc;
      ADDR_MCAUSE:  w_rdata = r_mcause;
      ADDR_MIP:     w_rdata = {24'd0, r_mtip, 7'd0};
      default:      w_rdata = '0;
    endcase
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.trap_req    = (r_state == S_REQ);
  assign bus.redirect_pc = (r_state == S_REQ) ? w_trap_vec :
                           bus.is_mret        ? r_mepc     : '0;
endmodule

// File: tb/tb_csr_intr_unit.sv
// Directed bench for csr_intr_unit: CSR access, trap entry/exit, MTIP races, vectoring, reset abort.
module tb_csr_intr_unit;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [31:0] RST_VEC   = 32'h0000_0200;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  csr_intr_unit_if u_if ();

  csr_intr_unit #(.MTVEC_RST(RST_VEC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    u_if.csr_we    = 1'b1;
    u_if.csr_addr  = addr;
    u_if.csr_wdata = data;
    @(negedge clk);
    u_if.csr_we    = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    u_if.csr_addr = addr;
    #1;
    data = u_if.csr_rdata;
  endtask

  task automatic pulse_timer();
    u_if.timer_intrpt = 1'b1;
    @(negedge clk);
    u_if.timer_intrpt = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rd(A_MSTATUS, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus got=%h exp=%h", d, 32'h0); end
    rd(A_MIE, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mie got=%h exp=%h", d, 32'h0); end
    rd(A_MTVEC, d); n_checks++;
    if (d !== RST_VEC) begin n_fail++; $display("FAIL reset_mtvec got=%h exp=%h", d, RST_VEC); end
    rd(A_MEPC, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got=%h exp=%h", d, 32'h0); end
    rd(A_MCAUSE, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mcause got=%h exp=%h", d, 32'h0); end
    rd(A_MIP, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mip got=%h exp=%h", d, 32'h0); end
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL reset_trap_req got=%b exp=0", u_if.trap_req); end
  endtask

  task automatic test_csr_access();
    logic [31:0] d;
    wr(A_MIP, 32'hFFFF_FFFF);
    rd(A_MIP, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mip_readonly got=%h exp=%h", d, 32'h0); end
    wr(12'h7C0, 32'h1234_5678);
    rd(12'h7C0, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); end
    wr(A_MEPC, 32'h0000_0043);
    rd(A_MEPC, d); n_checks++;
    if (d !== 32'h40) begin n_fail++; $display("FAIL mepc_align got=%h exp=%h", d, 32'h40); end
    wr(A_MSTATUS, 32'hFFFF_FF77);
    rd(A_MSTATUS, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mstatus_other_bits got=%h exp=%h", d, 32'h0); end
    wr(A_MCAUSE, 32'h0000_0005);
    rd(A_MCAUSE, d); n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL mcause_write got=%h exp=%h", d, 32'h5); end
  endtask

  task automatic test_basic_trap();
    logic [31:0] d;
    wr(A_MTVEC, 32'h0000_0100);
    wr(A_MIE, 32'h0000_0080);
    wr(A_MSTATUS, 32'h0000_0008);
    u_if.commit_valid = 1'b1;
    u_if.commit_pc    = 32'h0000_0040;
    pulse_timer();
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL trap_latency_early got=%b exp=0", u_if.trap_req); end
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL trap_req_assert got=%b exp=1", u_if.trap_req); end
    n_checks++;
    if (u_if.redirect_pc !== 32'h100) begin n_fail++; $display("FAIL trap_vector got=%h exp=%h", u_if.redirect_pc, 32'h100); end
    u_if.commit_pc = 32'h0000_0044;
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL trap_req_hold got=%b exp=1", u_if.trap_req); end
    rd(A_MEPC, d); n_checks++;
    if (d !== 32'h40) begin n_fail++; $display("FAIL mepc_latch got=%h exp=%h", d, 32'h40); end
    u_if.trap_ack = 1'b1;
    @(negedge clk);
    u_if.trap_ack     = 1'b0;
    u_if.commit_valid = 1'b0;
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL trap_req_after_ack got=%b exp=0", u_if.trap_req); end
    rd(A_MCAUSE, d); n_checks++;
    if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL mcause_trap got=%h exp=%h", d, 32'h8000_0007); end
    rd(A_MSTATUS, d); n_checks++;
    if (d !== 32'h80) begin n_fail++; $display("FAIL mstatus_trap got=%h exp=%h", d, 32'h80); end
    rd(A_MIP, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mip_cleared got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_mret();
    logic [31:0] d;
    u_if.is_mret = 1'b1;
    #1;
    n_checks++;
    if (u_if.redirect_pc !== 32'h40) begin n_fail++; $display("FAIL mret_redirect got=%h exp=%h", u_if.redirect_pc, 32'h40); end
    @(negedge clk);
    u_if.is_mret = 1'b0;
    rd(A_MSTATUS, d); n_checks++;
    if (d !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus got=%h exp=%h", d, 32'h88); end
    n_checks++;
    if (u_if.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL idle_redirect got=%h exp=%h", u_if.redirect_pc, 32'h0); end
  endtask

  task automatic test_masked_pulse();
    logic [31:0] d;
    wr(A_MSTATUS, 32'h0);
    u_if.commit_valid = 1'b1;
    u_if.commit_pc    = 32'h0000_0060;
    pulse_timer();
    repeat (2) @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL masked_no_trap got=%b exp=0", u_if.trap_req); end
    rd(A_MIP, d); n_checks++;
    if (d !== 32'h80) begin n_fail++; $display("FAIL masked_mtip got=%h exp=%h", d, 32'h80); end
    wr(A_MSTATUS, 32'h8);
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL enable_latency_early got=%b exp=0", u_if.trap_req); end
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL enable_trap got=%b exp=1", u_if.trap_req); end
    u_if.trap_ack = 1'b1;
    @(negedge clk);
    u_if.trap_ack = 1'b0;
    u_if.is_mret  = 1'b1;
    @(negedge clk);
    u_if.is_mret  = 1'b0;
    rd(A_MEPC, d); n_checks++;
    if (d !== 32'h60) begin n_fail++; $display("FAIL masked_mepc got=%h exp=%h", d, 32'h60); end
  endtask

  task automatic test_pulse_with_ack();
    logic [31:0] d;
    u_if.commit_pc = 32'h0000_0080;
    pulse_timer();
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL race_setup got=%b exp=1", u_if.trap_req); end
    u_if.trap_ack     = 1'b1;
    u_if.timer_intrpt = 1'b1;
    @(negedge clk);
    u_if.trap_ack     = 1'b0;
    u_if.timer_intrpt = 1'b0;
    rd(A_MIP, d); n_checks++;
    if (d !== 32'h80) begin n_fail++; $display("FAIL race_mtip got=%h exp=%h", d, 32'h80); end
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL handler_no_retrap got=%b exp=0", u_if.trap_req); end
    u_if.is_mret = 1'b1;
    @(negedge clk);
    u_if.is_mret   = 1'b0;
    u_if.commit_pc = 32'h0000_0084;
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL second_trap_early got=%b exp=0", u_if.trap_req); end
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL second_trap got=%b exp=1", u_if.trap_req); end
    rd(A_MEPC, d); n_checks++;
    if (d !== 32'h84) begin n_fail++; $display("FAIL second_mepc got=%h exp=%h", d, 32'h84); end
    // mret while a request is pending must be ignored
    u_if.is_mret = 1'b1;
    #1;
    n_checks++;
    if (u_if.redirect_pc !== 32'h100) begin n_fail++; $display("FAIL req_mret_redirect got=%h exp=%h", u_if.redirect_pc, 32'h100); end
    @(negedge clk);
    u_if.is_mret = 1'b0;
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL req_mret_ignored got=%b exp=1", u_if.trap_req); end
    wr(A_MSTATUS, 32'h0);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL mie_clear_keeps_req got=%b exp=1", u_if.trap_req); end
    // ack and mstatus write in the same cycle: hardware update wins
    u_if.trap_ack  = 1'b1;
    u_if.csr_we    = 1'b1;
    u_if.csr_addr  = A_MSTATUS;
    u_if.csr_wdata = 32'h8;
    @(negedge clk);
    u_if.trap_ack  = 1'b0;
    u_if.csr_we    = 1'b0;
    rd(A_MSTATUS, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL hw_beats_write got=%h exp=%h", d, 32'h0); end
    u_if.is_mret = 1'b1;
    @(negedge clk);
    u_if.is_mret = 1'b0;
    rd(A_MSTATUS, d); n_checks++;
    if (d !== 32'h80) begin n_fail++; $display("FAIL mret_restore_zero got=%h exp=%h", d, 32'h80); end
  endtask

  task automatic test_vectored_and_reset();
    logic [31:0] d;
    logic [31:0] exp_mtvec;
    logic [31:0] exp_vec;
`ifdef INTR_VECTORED_EN
    exp_mtvec = 32'h101;
    exp_vec   = 32'h11C;
`else
    exp_mtvec = 32'h100;
    exp_vec   = 32'h100;
`endif
    wr(A_MTVEC, 32'h0000_0101);
    rd(A_MTVEC, d); n_checks++;
    if (d !== exp_mtvec) begin n_fail++; $display("FAIL mtvec_mode_bits got=%h exp=%h", d, exp_mtvec); end
    wr(A_MSTATUS, 32'h8);
    u_if.commit_pc = 32'h0000_0090;
    pulse_timer();
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b1) begin n_fail++; $display("FAIL vec_trap_req got=%b exp=1", u_if.trap_req); end
    n_checks++;
    if (u_if.redirect_pc !== exp_vec) begin n_fail++; $display("FAIL vec_redirect got=%h exp=%h", u_if.redirect_pc, exp_vec); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    u_if.commit_valid = 1'b0;
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL reset_abort_req got=%b exp=0", u_if.trap_req); end
    n_checks++;
    if (u_if.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_abort_redirect got=%h exp=%h", u_if.redirect_pc, 32'h0); end
    rd(A_MCAUSE, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_abort_mcause got=%h exp=%h", d, 32'h0); end
    rd(A_MTVEC, d); n_checks++;
    if (d !== RST_VEC) begin n_fail++; $display("FAIL reset_abort_mtvec got=%h exp=%h", d, RST_VEC); end
    @(negedge clk);
    n_checks++;
    if (u_if.trap_req !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle got=%b exp=0", u_if.trap_req); end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst               = 1'b0;
    u_if.timer_intrpt = 1'b0;
    u_if.csr_we       = 1'b0;
    u_if.csr_addr     = 12'h0;
    u_if.csr_wdata    = 32'h0;
    u_if.commit_pc    = 32'h0;
    u_if.commit_valid = 1'b0;
    u_if.is_mret      = 1'b0;
    u_if.trap_ack     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    test_reset();
    test_csr_access();
    test_basic_trap();
    test_mret();
    test_masked_pulse();
    test_pulse_with_ack();
    test_vectored_and_reset();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
